// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the UART sender.
// Port names inside the bundle follow the sender's send/data/send_done link.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 40
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               send;
  logic [DW-1:0]      data;
  logic               send_done;
  logic               busy;
  logic [1:0]         grant_idx;
  logic               timeout_err;

  modport master (
    input  req, req_data, send_done,
    output ack, send, data, busy,
    output grant_idx, timeout_err
  );

  modport slave (
    output req, req_data, send_done,
    input  ack, send, data, busy,
    input  grant_idx, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among NREQ requesters.
// Latches the winner's word, holds send until send_done or timeout, acks.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 40,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_ACK, S_GAP
  } state_t;

  state_t          r_state, w_state_n;
  logic [1:0]      r_last, w_last_n;
  logic [1:0]      r_gidx, w_gidx_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [DW-1:0]   r_data, w_data_n;
  logic [NREQ-1:0] r_ack, w_ack_n;
  logic            r_send, w_send_n;
  logic            r_busy, w_busy_n;
  logic            r_terr, w_terr_n;
  logic [2:0]      w_pick;

  // {hit, idx}: nearest set bit after last, scanned downward so closest wins
  function automatic logic [2:0] f_pick(
    input logic [NREQ-1:0] req,
    input logic [1:0]      last
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, last};
    for (int i = NREQ; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick = f_pick(bus.req, r_last);

  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_gidx_n  = r_gidx;
    w_cnt_n   = r_cnt;
    w_data_n  = r_data;
    w_ack_n   = '0;
    w_send_n  = r_send;
    w_busy_n  = r_busy;
    w_terr_n  = r_terr;
    unique case (r_state)
      S_IDLE: begin
        w_send_n = 1'b0;
        w_busy_n = 1'b0;
        if (w_pick[2]) begin
          w_data_n  = bus.req_data[int'(w_pick[1:0])*DW +: DW];
          w_gidx_n  = w_pick[1:0];
          w_send_n  = 1'b1;
          w_busy_n  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.send_done) begin
          w_send_n        = 1'b0;
          w_ack_n[r_gidx] = 1'b1;
          w_state_n       = S_ACK;
        end else if (r_cnt == C_LAST) begin
          w_send_n        = 1'b0;
          w_ack_n[r_gidx] = 1'b1;
          w_terr_n        = 1'b1;
          w_state_n       = S_ACK;
        end else if (r_cnt != C_MAX) begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_ACK: begin
        w_last_n  = r_gidx;
        w_state_n = S_GAP;
      end
      S_GAP: begin
        w_send_n  = 1'b0;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 2'(NREQ - 1);
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ack   <= '0;
      r_send  <= 1'b0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_last  <= w_last_n;
      r_gidx  <= w_gidx_n;
      r_cnt   <= w_cnt_n;
      r_data  <= w_data_n;
      r_ack   <= w_ack_n;
      r_send  <= w_send_n;
      r_busy  <= w_busy_n;
      r_terr  <= w_terr_n;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.send        = r_send;
  assign bus.data        = r_data;
  assign bus.busy        = r_busy;
  assign bus.grant_idx   = r_gidx;
  assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a transfer-level model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_last;
  bit          m_terr;
  logic [39:0] m_word [4];

  uart_tx_arbiter_if ifc ();

  uart_tx_arbiter #(
    .NREQ(4), .DW(40), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  function automatic int pick(
    input logic [3:0] r,
    input int         last
  );
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic load_words();
    ifc.req_data = {m_word[3], m_word[2],
                    m_word[1], m_word[0]};
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++)
      m_word[i] = {8'($urandom), 32'($urandom)};
    load_words();
  endtask

  // One complete transfer, entered with req stable in IDLE or GAP
  task automatic xfer(
    input int dly,
    input bit to,
    input bit drop_early,
    input bit hold
  );
    int exp;
    int n;
    logic [39:0] w;
    exp = pick(ifc.req, m_last);
    if (exp < 0) begin
      check("no_req", 0, 1);
      return;
    end
    w = m_word[exp];
    n = 0;
    while (!ifc.send && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.send) begin
      check("grant_wait", 0, 1);
      return;
    end
    check("grant_idx", ifc.grant_idx, exp);
    check("data", ifc.data, w);
    check("busy", ifc.busy, 1);
    if (drop_early) ifc.req[exp] = 1'b0;
    if (to) begin
      n = 0;
      while (ifc.send && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("to_len", n, TO);
      m_terr = 1'b1;
    end else begin
      repeat (dly) @(negedge clk);
      check("send_hold", ifc.send, 1);
      check("data_hold", ifc.data, w);
      ifc.send_done = 1'b1;
      @(negedge clk);
      ifc.send_done = 1'b0;
    end
    check("ack", ifc.ack, 4'b1 << exp);
    check("ack_send", ifc.send, 0);
    check("terr", ifc.timeout_err, m_terr);
    if (!hold) ifc.req[exp] = 1'b0;
    @(negedge clk);
    check("gap_ack", ifc.ack, 0);
    check("gap_send", ifc.send, 0);
    m_last = exp;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    ifc.req = '0;
    ifc.send_done = 1'b0;
    for (int i = 0; i < 4; i++) m_word[i] = '0;
    load_words();
    m_last = 3;
    m_terr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_send", ifc.send, 0);
    check("rst_data", ifc.data, 0);
    check("rst_ack", ifc.ack, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_gidx", ifc.grant_idx, 0);
    check("rst_terr", ifc.timeout_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // single requester 2
    m_word[2] = 40'h12_3456_789A;
    load_words();
    ifc.req = 4'b0100;
    xfer(5, 0, 0, 0);
    @(negedge clk);
    check("t1_idle_busy", ifc.busy, 0);

    // all held: rotation
    rand_words();
    ifc.req = 4'b1111;
    for (int i = 0; i < 5; i++) xfer(3, 0, 0, 1);
    ifc.req = '0;
    @(negedge clk);

    // 1 then {1,3} together: 3 first
    ifc.req = 4'b0010;
    xfer(2, 0, 0, 0);
    ifc.req = 4'b1010;
    xfer(1, 0, 0, 0);
    xfer(0, 0, 0, 0);

    // timeout, then sticky error through good transfers
    rand_words();
    ifc.req = 4'b0001;
    xfer(0, 1, 0, 0);
    ifc.req = 4'b0100;
    xfer(4, 0, 0, 0);
    check("terr_sticky", ifc.timeout_err, 1);

    // reset two cycles into SEND
    rand_words();
    ifc.req = 4'b1000;
    n = 0;
    while (!ifc.send && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("t5_send", ifc.send, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_send_rst", ifc.send, 0);
    check("t5_data_rst", ifc.data, 0);
    check("t5_ack_rst", ifc.ack, 0);
    check("t5_busy_rst", ifc.busy, 0);
    check("t5_terr_rst", ifc.timeout_err, 0);
    m_terr = 1'b0;
    m_last = 3;
    @(negedge clk);
    rst = 1'b1;
    ifc.req = 4'b1001;
    @(negedge clk);
    check("t5_no_ack", ifc.ack, 0);
    xfer(1, 0, 0, 0);
    xfer(1, 0, 0, 0);

    // send_done in IDLE ignored; req dropped mid-SEND
    ifc.send_done = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy", ifc.busy, 0);
    check("t6_send", ifc.send, 0);
    check("t6_ack", ifc.ack, 0);
    ifc.send_done = 1'b0;
    rand_words();
    ifc.req = 4'b0010;
    xfer(3, 0, 1, 0);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      rand_words();
      ifc.req = ifc.req | 4'($urandom);
      if (ifc.req == 4'b0)
        ifc.req = 4'($urandom_range(1, 15));
      xfer($urandom_range(0, 6), 0,
           ($urandom % 4) == 0,
           ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
